// File: rtl/usb_dev_txn.sv
// usb_dev_txn: device-side USB transaction responder.
// OUT tokens to the page/data endpoint latch a 16-bit page and then write
// 64-bit data into device memory; IN tokens to the read endpoint fetch a
// memory word and return it as a DATA packet. All outputs are registered.
module usb_dev_txn #(
    parameter logic [6:0] DEV_ADDR  = 7'b1010000,
    parameter logic [3:0] ADDR_ENDP = 4'b0010,
    parameter logic [3:0] READ_ENDP = 4'b0001,
    parameter logic [7:0] TIMEOUT   = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tok_valid,
    input  logic [18:0] tok_pkt,
    input  logic        dpkt_valid,
    input  logic [71:0] dpkt,
    input  logic        dpkt_ok,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    output logic        mem_re,
    input  logic [63:0] mem_rdata,
    output logic        tx_valid,
    output logic [71:0] tx_pkt,
    input  logic        tx_ready,
    output logic        ack,
    output logic        nak,
    output logic        busy
);

    localparam logic [7:0] PID_OUT  = 8'b10000111;
    localparam logic [7:0] PID_IN   = 8'b10010110;
    localparam logic [7:0] PID_DATA = 8'b11000011;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_ADDR = 3'd1,
        PAGED   = 3'd2,
        RX_DATA = 3'd3,
        RD_REQ  = 3'd4,
        RD_CAP  = 3'd5,
        TX      = 3'd6
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  tcount_reg, tcount_next;
    logic [15:0] page_reg, page_next;
    logic [63:0] wdata_reg, wdata_next;
    logic [71:0] tx_pkt_reg, tx_pkt_next;
    logic        we_reg, we_next;
    logic        re_reg, re_next;
    logic        tx_valid_reg, tx_valid_next;
    logic        ack_reg, ack_next;
    logic        nak_reg, nak_next;
    logic        busy_reg, busy_next;

    // Payload and read data travel LSB-first on the wire; flip them here.
    logic [63:0] payload_rev;
    logic [63:0] rdata_rev;

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_rev
            assign payload_rev[gi] = dpkt[63-gi];
            assign rdata_rev[gi]   = mem_rdata[63-gi];
        end
    endgenerate

    // Token decode: only the two recognised tokens for this device matter.
    logic is_out, is_in, good_data, in_rx, timeout_hit;

    assign is_out = tok_valid && (tok_pkt[18:11] == PID_OUT)
                    && (tok_pkt[10:4] == DEV_ADDR) && (tok_pkt[3:0] == ADDR_ENDP);
    assign is_in  = tok_valid && (tok_pkt[18:11] == PID_IN)
                    && (tok_pkt[10:4] == DEV_ADDR) && (tok_pkt[3:0] == READ_ENDP);
    assign good_data   = dpkt_valid && dpkt_ok && (dpkt[71:64] == PID_DATA);
    assign in_rx       = (state_reg == RX_ADDR) || (state_reg == RX_DATA);
    assign timeout_hit = (tcount_reg == TIMEOUT);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a data packet outranks a token or timeout in RX states.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (is_out) state_next = RX_ADDR;
            end
            RX_ADDR: begin
                if (good_data)                       state_next = PAGED;
                else if (dpkt_valid)                 state_next = IDLE;
                else if (tok_valid || timeout_hit)   state_next = IDLE;
            end
            PAGED: begin
                if (is_out)     state_next = RX_DATA;
                else if (is_in) state_next = RD_REQ;
            end
            RX_DATA: begin
                if (good_data)                       state_next = IDLE;
                else if (dpkt_valid)                 state_next = PAGED;
                else if (tok_valid || timeout_hit)   state_next = PAGED;
            end
            RD_REQ:  state_next = RD_CAP;
            RD_CAP:  state_next = TX;
            TX: begin
                if (tx_valid_reg && tx_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values of every registered output and datapath reg.
    always_comb begin
        ack_next      = 1'b0;
        nak_next      = 1'b0;
        we_next       = 1'b0;
        re_next       = 1'b0;
        page_next     = page_reg;
        wdata_next    = wdata_reg;
        tx_pkt_next   = tx_pkt_reg;
        tx_valid_next = (state_next == TX);
        busy_next     = (state_next != IDLE) && (state_next != PAGED);
        // Counter restarts whenever we are outside the RX states, so it reads
        // zero on the first cycle after entering one.
        tcount_next   = in_rx ? tcount_reg + 8'd1 : 8'd0;

        case (state_reg)
            IDLE: begin
                if (is_in) nak_next = 1'b1;
            end
            RX_ADDR: begin
                if (good_data) begin
                    ack_next  = 1'b1;
                    page_next = payload_rev[63:48];
                end else if (dpkt_valid || tok_valid || timeout_hit) begin
                    nak_next = 1'b1;
                end
            end
            PAGED: begin
                if (!is_out && is_in) re_next = 1'b1;
            end
            RX_DATA: begin
                if (good_data) begin
                    ack_next   = 1'b1;
                    we_next    = 1'b1;
                    wdata_next = payload_rev;
                end else if (dpkt_valid || tok_valid || timeout_hit) begin
                    nak_next = 1'b1;
                end
            end
            RD_CAP: begin
                tx_pkt_next = {PID_DATA, rdata_rev};
            end
            TX: begin
                if (tx_valid_reg && tx_ready) ack_next = 1'b1;
            end
            default: ;
        endcase
    end

    // Output and datapath registers; reset clears everything including TX.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcount_reg   <= 8'd0;
            page_reg     <= 16'h0;
            wdata_reg    <= 64'h0;
            tx_pkt_reg   <= 72'h0;
            we_reg       <= 1'b0;
            re_reg       <= 1'b0;
            tx_valid_reg <= 1'b0;
            ack_reg      <= 1'b0;
            nak_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            tcount_reg   <= tcount_next;
            page_reg     <= page_next;
            wdata_reg    <= wdata_next;
            tx_pkt_reg   <= tx_pkt_next;
            we_reg       <= we_next;
            re_reg       <= re_next;
            tx_valid_reg <= tx_valid_next;
            ack_reg      <= ack_next;
            nak_reg      <= nak_next;
            busy_reg     <= busy_next;
        end
    end

    assign mem_addr  = page_reg;
    assign mem_we    = we_reg;
    assign mem_wdata = wdata_reg;
    assign mem_re    = re_reg;
    assign tx_valid  = tx_valid_reg;
    assign tx_pkt    = tx_pkt_reg;
    assign ack       = ack_reg;
    assign nak       = nak_reg;
    assign busy      = busy_reg;

endmodule

// File: doc/usb_dev_txn.md
# usb_dev_txn

Device-side transaction responder for the host read/write USB link. It consumes token and data packets already framed and CRC-checked by the device receive layer. OUT-to-endpoint-4 sequences latch a 16-bit memory page and then write 64-bit data into device memory. IN-to-endpoint-8 tokens read memory and return a data packet to the device transmit layer.

## Interface
- DEV_ADDR, 7'b1010000, device address matched in token packets
- ADDR_ENDP, 4'b0010, endpoint field (wire bit order) for page/data OUT transfers
- READ_ENDP, 4'b0001, endpoint field (wire bit order) for IN reads
- TIMEOUT, 255, max cycles waiting for a data packet after an OUT token
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- tok_valid  in  1  tok_pkt valid this cycle (single-cycle pulse)
- tok_pkt  in  19  {PID[7:0], addr[6:0], endp[3:0]}
- dpkt_valid  in  1  dpkt valid this cycle (single-cycle pulse)
- dpkt  in  72  {PID[7:0], payload[63:0]}; payload is bit-reversed (LSB-first wire order)
- dpkt_ok  in  1  receive-layer CRC pass for dpkt; qualified by dpkt_valid
- mem_addr  out  16  latched page
- mem_we  out  1  one-cycle write strobe
- mem_wdata  out  64  un-reversed write data
- mem_re  out  1  one-cycle read strobe
- mem_rdata  in  64  read data, valid the cycle after mem_re
- tx_valid  out  1  response data packet valid; held until tx_ready
- tx_pkt  out  72  {8'b11000011, reverse(read data)}
- tx_ready  in  1  transmit layer accepts tx_pkt when tx_valid & tx_ready
- ack  out  1  one-cycle handshake pulse, success
- nak  out  1  one-cycle handshake pulse, failure
- busy  out  1  state != IDLE and state != PAGED

## Operation
- reverse(x)[i] = x[63-i]. Good data packet: dpkt_valid & dpkt_ok & PID == 8'b11000011.
- OUT token: PID 8'b10000111, addr == DEV_ADDR, endp == ADDR_ENDP. IN token: PID 8'b10010110, addr == DEV_ADDR, endp == READ_ENDP. All other tokens: "foreign", ignored with no response.
- IDLE: OUT token -> RX_ADDR. IN token -> nak, stay IDLE (no page held).
- RX_ADDR: good data -> page <= reverse(payload)[63:48], ack, -> PAGED. Bad data (any dpkt_valid not good) -> nak, -> IDLE. Timeout -> nak, -> IDLE.
- PAGED: page held. OUT token -> RX_DATA. IN token -> RD_REQ.
- RX_DATA: good data -> mem_we with mem_wdata = reverse(payload), ack, -> IDLE. Bad data -> nak, -> PAGED so the host may retry. Timeout -> nak, -> PAGED.
- RD_REQ: mem_re for 1 cycle -> RD_CAP.
- RD_CAP: capture mem_rdata -> TX.
- TX: tx_valid high, tx_pkt stable. On tx_valid & tx_ready -> ack, -> IDLE.
- Token (matching or foreign) arriving in RX_ADDR/RX_DATA without dpkt_valid: nak, same exit as timeout. If it arrives with dpkt_valid in the same cycle, the data packet is processed and the token is dropped.
- Tokens and data packets arriving in RD_REQ/RD_CAP/TX are dropped silently. Data packets arriving in IDLE/PAGED are dropped silently.

## Timing
- All outputs are registered. Reset: state IDLE, page 16'h0; mem_we, mem_re, tx_valid, ack, nak, busy all 0; mem_wdata, tx_pkt 0. Reset has priority over every input and aborts any state, including TX with tx_valid high.
- Input event in cycle t -> state, ack/nak, mem_we visible in cycle t+1.
- Read: IN token at t -> mem_re at t+1 -> rdata sampled end of t+2 -> tx_valid from t+3. If tx_ready is already high at t+3, ack is at t+4.
- Timeout counter: 8-bit minimum width. Clears on entering RX_ADDR/RX_DATA and increments each cycle. When count == TIMEOUT with no dpkt_valid, the block naks and exits on the next edge. A dpkt_valid on the expiry cycle wins over the timeout.
- mem_addr holds page continuously; it changes only on a good address packet or on reset.
- ack and nak are never asserted together. mem_we and mem_re are never asserted together.

## Test plan
- Write: OUT token, then data payload reverse({16'h00A5, 48'b0}), then OUT token, then data payload reverse(64'hDEADBEEF_01234567). Expect two acks, mem_addr = 16'h00A5, and one mem_we with mem_wdata = 64'hDEADBEEF_01234567.
- Read: page 16'h0001 set, IN token, mem_rdata = 64'h1. Expect mem_re at t+1, tx_valid at t+3, tx_pkt = {8'hC3, 64'h8000_0000_0000_0000}, and ack after tx_ready.
- Backpressure: hold tx_ready low 10 cycles during a read. Expect tx_pkt stable and tx_valid high throughout, with no ack until the tx_ready cycle.
- Error: in RX_DATA, send dpkt_ok = 0. Expect nak, no mem_we, and state PAGED. Then a retried good packet gives ack + mem_we.
- Timeout / IN without page: after reset send an IN token, expect nak. Send OUT, then nothing for TIMEOUT+1 cycles, expect one nak and return to IDLE.
- Reset mid-operation: assert rst while in TX. Next cycle expect tx_valid = 0, mem_addr = 0, and a subsequent IN token to be naked.
